// File: rtl/multitap_keypad_encoder.sv
// multitap_keypad_encoder
// Scans an ROWS x COLS matrix keypad, debounces whole scan frames and turns
// repeated presses of a letter key into uppercase ASCII letters (multi-tap).
// The last two keys are submit and clear. One instance per role (host / player).
// Optional build macro: MULTITAP_AUTO_COMMIT_EN commits a pending letter after
// TAP_TIMEOUT idle cycles in TAP.
//
// Handshake note: there is no backpressure. letter_valid, submit and clear are
// single-cycle pulses that the consumer must sample on the cycle they are high;
// letter holds the last committed value until the next commit.
module multitap_keypad_encoder #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int TAPS            = 3,
  parameter int SCAN_HOLD       = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int TAP_TIMEOUT     = 1000
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col_drive,
  output logic [7:0]      preview,
  output logic            preview_active,
  output logic [7:0]      letter,
  output logic            letter_valid,
  output logic            submit,
  output logic            clear
);

  localparam int NKEYS = ROWS * COLS;
  localparam int NLK   = (26 + TAPS - 1) / TAPS;
  localparam int KW    = $clog2(NKEYS + 1);
  localparam int TW    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int HW    = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW    = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [KW-1:0] KEY_NONE   = KW'(NKEYS);
  localparam logic [KW-1:0] KEY_SUBMIT = KW'(NKEYS - 1);
  localparam logic [KW-1:0] KEY_CLEAR  = KW'(NKEYS - 2);

  // Parameter sanity: the keypad must hold every letter key plus submit and clear.
  generate
    if (NKEYS < NLK + 2) begin : g_bad_size
      $error("multitap_keypad_encoder: ROWS*COLS too small for letter keys + submit + clear");
    end
    if (SCAN_HOLD < 1 || DEBOUNCE_FRAMES < 1 || TAP_TIMEOUT < 1 || TAPS < 1) begin : g_bad_param
      $error("multitap_keypad_encoder: SCAN_HOLD, DEBOUNCE_FRAMES, TAP_TIMEOUT, TAPS must be >= 1");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, TAP = 1'b1} state_t;

  // ASCII of key k at tap count t.
  function automatic logic [7:0] char_of(input logic [KW-1:0] k, input logic [TW-1:0] t);
    int code;
    code = 'h41 + int'(k) * TAPS + int'(t);
    return code[7:0];
  endfunction

  // Next tap count: wraps after TAPS letters or when the letter would pass 'Z'.
  function automatic logic [TW-1:0] tap_next(input logic [KW-1:0] k, input logic [TW-1:0] t);
    int nt;
    nt = int'(t) + 1;
    if (nt >= TAPS || ('h41 + int'(k) * TAPS + nt) > 'h5A) nt = 0;
    return nt[TW-1:0];
  endfunction

  // ---------------------------------------------------------------- scanner
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] col_idx, col_next;
  logic [KW-1:0] col_key, frame_min, best;
  logic          sample, last_col, frame_end;

  assign sample    = (hold_cnt == HW'(SCAN_HOLD - 1));
  assign last_col  = (col_idx == CW'(COLS - 1));
  assign col_next  = last_col ? '0 : col_idx + 1'b1;
  assign best      = (col_key < frame_min) ? col_key : frame_min;
  assign frame_end = sample && last_col;

  // Lowest active row in the driven column gives the lowest key of that column.
  always_comb begin
    col_key = KEY_NONE;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row[r]) col_key = KW'(r * COLS + int'(col_idx));
    end
  end

  // Column rotation and per-frame minimum key tracking.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hold_cnt  <= '0;
      col_idx   <= '0;
      col_drive <= COLS'(1);
      frame_min <= KEY_NONE;
    end else if (sample) begin
      hold_cnt  <= '0;
      col_idx   <= col_next;
      col_drive <= COLS'(1) << col_next;
      frame_min <= last_col ? KEY_NONE : best;
    end else begin
      hold_cnt  <= hold_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------- debouncer
  logic          pressed, press_evt;
  logic [KW-1:0] db_key, press_key;
  logic [DW-1:0] db_cnt, db_run, rel_run;

  assign db_run  = (best == db_key) ? db_cnt + 1'b1 : DW'(1);
  assign rel_run = db_cnt + 1'b1;

  // Frame-level debounce: one press event per hold, release needs quiet frames.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pressed   <= 1'b0;
      press_evt <= 1'b0;
      press_key <= KEY_NONE;
      db_key    <= KEY_NONE;
      db_cnt    <= '0;
    end else begin
      press_evt <= 1'b0;
      if (frame_end) begin
        if (!pressed) begin
          if (best == KEY_NONE) begin
            db_key <= KEY_NONE;
            db_cnt <= '0;
          end else if (db_run >= DW'(DEBOUNCE_FRAMES)) begin
            press_evt <= 1'b1;
            press_key <= best;
            pressed   <= 1'b1;
            db_key    <= best;
            db_cnt    <= '0;
          end else begin
            db_key <= best;
            db_cnt <= db_run;
          end
        end else begin
          if (best != KEY_NONE) begin
            db_cnt <= '0;
          end else if (rel_run >= DW'(DEBOUNCE_FRAMES)) begin
            pressed <= 1'b0;
            db_key  <= KEY_NONE;
            db_cnt  <= '0;
          end else begin
            db_cnt <= rel_run;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------- tap FSM
  state_t        state, state_d;
  logic [KW-1:0] cand_key, cand_d;
  logic [TW-1:0] tap, tap_d;
  logic [7:0]    letter_d, preview_d;
  logic          lv_d, submit_d, clear_d;
  logic          is_letter, is_submit, is_clear;

  assign is_letter = press_evt && (press_key < KW'(NLK));
  assign is_submit = press_evt && (press_key == KEY_SUBMIT);
  assign is_clear  = press_evt && (press_key == KEY_CLEAR);

`ifdef MULTITAP_AUTO_COMMIT_EN
  localparam int TMW = $clog2(TAP_TIMEOUT + 1);
  logic [TMW-1:0] timer, timer_d;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state;
    cand_d   = cand_key;
    tap_d    = tap;
    letter_d = letter;
    lv_d     = 1'b0;
    submit_d = 1'b0;
    clear_d  = 1'b0;
`ifdef MULTITAP_AUTO_COMMIT_EN
    timer_d  = '0;
`endif
    case (state)
      IDLE: begin
        if (is_letter) begin
          cand_d  = press_key;
          tap_d   = '0;
          state_d = TAP;
        end else if (is_submit) begin
          submit_d = 1'b1;
        end else if (is_clear) begin
          clear_d = 1'b1;
        end
      end
      TAP: begin
        if (is_letter && press_key == cand_key) begin
          tap_d = tap_next(cand_key, tap);
        end else if (is_letter) begin
          letter_d = char_of(cand_key, tap);
          lv_d     = 1'b1;
          cand_d   = press_key;
          tap_d    = '0;
        end else if (is_submit) begin
          letter_d = char_of(cand_key, tap);
          lv_d     = 1'b1;
          submit_d = 1'b1;
          tap_d    = '0;
          state_d  = IDLE;
        end else if (is_clear) begin
          clear_d = 1'b1;
          tap_d   = '0;
          state_d = IDLE;
        end else begin
`ifdef MULTITAP_AUTO_COMMIT_EN
          if (timer >= TMW'(TAP_TIMEOUT)) begin
            letter_d = char_of(cand_key, tap);
            lv_d     = 1'b1;
            tap_d    = '0;
            state_d  = IDLE;
          end else begin
            timer_d = timer + 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    preview_d = (state_d == TAP) ? char_of(cand_d, tap_d) : 8'h00;
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state          <= IDLE;
      cand_key       <= '0;
      tap            <= '0;
      letter         <= 8'h00;
      letter_valid   <= 1'b0;
      submit         <= 1'b0;
      clear          <= 1'b0;
      preview        <= 8'h00;
      preview_active <= 1'b0;
`ifdef MULTITAP_AUTO_COMMIT_EN
      timer          <= '0;
`endif
    end else begin
      state          <= state_d;
      cand_key       <= cand_d;
      tap            <= tap_d;
      letter         <= letter_d;
      letter_valid   <= lv_d;
      submit         <= submit_d;
      clear          <= clear_d;
      preview        <= preview_d;
      preview_active <= (state_d == TAP);
`ifdef MULTITAP_AUTO_COMMIT_EN
      timer          <= timer_d;
`endif
    end
  end

endmodule
